// File: rtl/data_memory_mmio.sv
`default_nettype none
// data_memory_mmio: word-addressed data RAM plus an MMIO window with a TX FIFO,
// a status register and a free-running cycle counter. Rev 1.0
module data_memory_mmio #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);
  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FIFO_AW + 1;
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(FIFO_DEPTH);

  logic [31:0]        r_ram  [RAM_WORDS];
  logic [31:0]        r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;
  logic [31:0]        r_cycles;

  logic              w_mmio;
  logic [1:0]        w_sel;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_pop;
  logic              w_status_wr;
  logic              w_cycles_wr;
  logic              w_full;
  logic              w_empty;
  logic [31:0]       w_status;
  logic              w_unused;

  assign w_mmio      = ALUResult[31];
  assign w_sel       = ALUResult[3:2];
  assign w_ram_idx   = ALUResult[RAM_AW+1:2];
  assign w_unused    = &{1'b0, ALUResult[1:0], ALUResult[30:RAM_AW+2]};

  assign w_push_req  = MemWrite & w_mmio & (w_sel == 2'd0);
  assign w_status_wr = MemWrite & w_mmio & (w_sel == 2'd1);
  assign w_cycles_wr = MemWrite & w_mmio & (w_sel == 2'd2);

  assign w_full      = (r_count == C_FULL);
  assign w_empty     = (r_count == '0);
  assign tx_valid    = ~w_empty;
  assign tx_data     = w_empty ? 32'd0 : r_fifo[r_rptr];
  assign w_pop       = tx_valid & tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok   = w_push_req & (~w_full | w_pop);

  assign w_status    = {24'd0, 5'(r_count), r_overflow, w_empty, w_full};

  always_comb begin
    ReadData = 32'd0;
    if (!w_mmio) begin
      ReadData = r_ram[w_ram_idx];
    end else begin
      case (w_sel)
        2'd1:    ReadData = w_status;
        2'd2:    ReadData = r_cycles;
        default: ReadData = 32'd0;
      endcase
    end
  end

  // Storage arrays carry no reset so RAM survives a mid-operation reset.
  always_ff @(posedge clk) begin
    if (MemWrite && !w_mmio) begin
      r_ram[w_ram_idx] <= WriteData;
    end
    if (w_push_ok) begin
      r_fifo[r_wptr] <= WriteData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_cycles   <= 32'd0;
    end else begin
      r_cycles <= w_cycles_wr ? WriteData : r_cycles + 32'd1;
      if (w_push_ok) begin
        r_wptr <= r_wptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + FIFO_AW'(1);
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // A dropped push wins over a concurrent clear.
      if (w_push_req && !w_push_ok) begin
        r_overflow <= 1'b1;
      end else if (w_status_wr) begin
        r_overflow <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_data_memory_mmio.sv
`default_nettype none
// tb_data_memory_mmio: directed self-checking bench for data_memory_mmio.
// Rev 1.0
module tb_data_memory_mmio;
  localparam logic [31:0] C_TXDATA = 32'h8000_0000;
  localparam logic [31:0] C_STATUS = 32'h8000_0004;
  localparam logic [31:0] C_CYCLES = 32'h8000_0008;
  localparam logic [31:0] C_RSVD   = 32'h8000_000C;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  data_memory_mmio #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] data);
    MemWrite  = we;
    ALUResult = addr;
    WriteData = data;
    #1;
  endtask

  initial begin
    reset = 1'b0; MemWrite = 1'b0; ALUResult = C_STATUS; WriteData = 32'd0; tx_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    drive(1'b0, C_CYCLES, 32'd0);
    chk("cycles_in_reset", ReadData, 32'd0);
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, C_STATUS, 32'd0);
    chk("reset_status", ReadData, 32'h0000_0002);
    chk("reset_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("reset_tx_data", tx_data, 32'd0);

    // RAM store/load, same-cycle read-old, aliasing
    drive(1'b1, 32'h0000_0010, 32'h1111_1111);
    tick();
    drive(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("ram_read_old", ReadData, 32'h1111_1111);
    tick();
    drive(1'b0, 32'h0000_0010, 32'd0);
    chk("ram_read_new", ReadData, 32'hDEAD_BEEF);
    drive(1'b0, 32'h0000_0110, 32'd0);
    chk("ram_alias", ReadData, 32'hDEAD_BEEF);

    // Fill past capacity with no drain
    for (int v = 1; v <= 5; v++) begin
      drive(1'b1, C_TXDATA, 32'(v));
      tick();
    end
    drive(1'b0, C_STATUS, 32'd0);
    chk("status_full_ovf", ReadData, 32'h0000_0025);
    chk("head_held", tx_data, 32'd1);
    drive(1'b0, C_TXDATA, 32'd0);
    chk("txdata_read_zero", ReadData, 32'd0);

    tx_ready = 1'b1;
    for (int v = 1; v <= 4; v++) begin
      #1;
      chk("drain_valid", {31'd0, tx_valid}, 32'd1);
      chk("drain_data", tx_data, 32'(v));
      tick();
    end
    drive(1'b0, C_STATUS, 32'd0);
    chk("drained_valid", {31'd0, tx_valid}, 32'd0);
    chk("drained_data", tx_data, 32'd0);
    chk("status_empty_ovf", ReadData, 32'h0000_0006);
    drive(1'b1, C_STATUS, 32'd0);
    tick();
    drive(1'b0, C_STATUS, 32'd0);
    chk("status_ovf_clear", ReadData, 32'h0000_0002);

    // Push into a full FIFO while it drains
    tx_ready = 1'b0;
    for (int v = 5; v <= 8; v++) begin
      drive(1'b1, C_TXDATA, 32'(v));
      tick();
    end
    drive(1'b0, C_STATUS, 32'd0);
    chk("status_full", ReadData, 32'h0000_0021);
    tx_ready = 1'b1;
    drive(1'b1, C_TXDATA, 32'd9);
    chk("full_pop_head", tx_data, 32'd5);
    tick();
    drive(1'b0, C_STATUS, 32'd0);
    chk("full_push_pop_status", ReadData, 32'h0000_0021);
    for (int v = 6; v <= 9; v++) begin
      chk("seq_data", tx_data, 32'(v));
      tick();
    end
    chk("seq_end_valid", {31'd0, tx_valid}, 32'd0);
    chk("seq_end_status", ReadData, 32'h0000_0002);

    // Cycle counter load and wrap
    tx_ready = 1'b0;
    drive(1'b1, C_CYCLES, 32'hFFFF_FFFE);
    tick();
    drive(1'b0, C_CYCLES, 32'd0);
    chk("cycles_load", ReadData, 32'hFFFF_FFFE);
    tick();
    chk("cycles_max", ReadData, 32'hFFFF_FFFF);
    tick();
    chk("cycles_wrap", ReadData, 32'h0000_0000);

    // Reserved register
    drive(1'b1, C_RSVD, 32'h0000_0123);
    chk("rsvd_read", ReadData, 32'd0);
    tick();
    drive(1'b0, C_STATUS, 32'd0);
    chk("rsvd_write_ignored", ReadData, 32'h0000_0002);

    // Reset mid-drain leaves RAM intact
    drive(1'b1, 32'h0000_0020, 32'hCAFE_F00D);
    tick();
    drive(1'b1, C_TXDATA, 32'h0000_000A);
    tick();
    drive(1'b1, C_TXDATA, 32'h0000_000B);
    tick();
    drive(1'b0, C_STATUS, 32'd0);
    tx_ready = 1'b1;
    tick();
    chk("middrain_data", tx_data, 32'h0000_000B);
    reset = 1'b1;
    #1;
    chk("reset_valid_drop", {31'd0, tx_valid}, 32'd0);
    chk("reset_data_drop", tx_data, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, C_STATUS, 32'd0);
    chk("post_reset_status", ReadData, 32'h0000_0002);
    drive(1'b0, 32'h0000_0020, 32'd0);
    chk("ram_survives_reset", ReadData, 32'hCAFE_F00D);
    drive(1'b0, 32'h0000_0010, 32'd0);
    chk("ram_survives_reset2", ReadData, 32'hDEAD_BEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/data_memory_mmio.md
# data_memory_mmio

Data-side memory block driven directly by the single-cycle core's data interface. It holds word-addressed data RAM and a small memory-mapped I/O window containing a TX FIFO with a valid/ready drain port, a status register and a free-running cycle counter. It consumes the core's `MemWrite`, `ALUResult` (byte address) and `WriteData`, and returns `ReadData` combinationally in the same cycle, as the single-cycle datapath requires.

## Interface
Parameters:
- `RAM_WORDS`, 64: data RAM depth in 32-bit words; power of two.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the core.
- `ALUResult`  in  32  byte address from the core.
- `WriteData`  in  32  store data from the core.
- `ReadData`  out  32  combinational load data to the core.
- `tx_data`  out  32  FIFO head word.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  downstream accepts the head word.

## Operation
- Address decode uses `ALUResult[31]` to select the region; bits [1:0] are ignored, so all accesses are word-aligned.
- RAM region (`ALUResult[31]`=0):
  - Index is `ALUResult[log2(RAM_WORDS)+1:2]`; higher bits alias.
  - Read is asynchronous. Write is synchronous when `MemWrite`=1.
  - RAM contents are not reset.
- MMIO region (`ALUResult[31]`=1, decoded on `ALUResult[3:2]`, other bits ignored):
  - `0x8000_0000` TXDATA: a write pushes `WriteData`; a read returns 0.
  - `0x8000_0004` STATUS, read:
    - bit0 full
    - bit1 empty
    - bit2 overflow (sticky)
    - bits[7:3] count
    - other bits 0
  - STATUS, write: any write clears overflow.
  - `0x8000_0008` CYCLES: a read returns the counter. A write loads `WriteData`; the counter's next value is `WriteData`, not `WriteData`+1.
  - `0x8000_000C`: reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(FIFO_DEPTH)+1. Pointers wrap modulo `FIFO_DEPTH`.
  - pop = `tx_valid` & `tx_ready`.
  - push = `MemWrite` & TXDATA selected.
  - A push is accepted if count < `FIFO_DEPTH` or a pop occurs in the same cycle.
  - A push that is not accepted is dropped and sets overflow. Overflow stays set until a STATUS write.
  - If a STATUS write and an overflow event occur in the same cycle, overflow is set.
  - Simultaneous push and pop leaves count unchanged; both pointers advance.
- `tx_data` = head entry when non-empty, otherwise 0. `tx_valid` = (count != 0).
- CYCLES increments by 1 every cycle, wrapping from `0xFFFF_FFFF` to 0.

## Timing
- Reset values:
  - count=0, both pointers 0, overflow=0, CYCLES=0.
  - `tx_valid`=0 and `tx_data`=0.
  - `ReadData` follows the decode: for example, a STATUS read gives `0x0000_0002`.
- Load latency is 0 cycles: `ReadData` is combinational from `ALUResult` and current state.
- A read of an address being written in the same cycle returns the old value. The new value is visible in the following cycle.
- Push-to-`tx_valid` latency is 1 cycle: the word pushed at edge N is presented as `tx_valid`=1 after edge N.
- Handshake rules:
  - A transfer completes at the rising edge where `tx_valid`=1 and `tx_ready`=1.
  - `tx_data` and `tx_valid` are stable while `tx_valid`=1 and `tx_ready`=0.
  - `tx_ready` may be high while `tx_valid`=0; this has no effect.
- Asserting `reset` mid-operation immediately empties the FIFO, deasserts `tx_valid`, and clears CYCLES and overflow. RAM is untouched.
- There is no combinational path from `tx_ready` to `ReadData` except through registered state.

## Test plan
- Reset, then read `0x8000_0004` → `ReadData`=`0x0000_0002`, `tx_valid`=0, `tx_data`=0.
- Store `0xDEADBEEF` at `0x0000_0010`, then load `0x0000_0010` and `0x0000_0110` (alias at `RAM_WORDS`=64) → both return `0xDEADBEEF`. In the store cycle, a load of the same address returns the prior value.
- With `tx_ready`=0, push 1, 2, 3, 4, 5 → STATUS reads `0x25` (count 4, full, overflow). Raise `tx_ready` → `tx_data` sequence is 1, 2, 3, 4, one word per cycle, then `tx_valid`=0 and STATUS=`0x06`.
- With the FIFO full and `tx_ready`=1, push 9 → push is accepted, count stays 4, overflow is not set, and 9 is delivered last.
- Write `0xFFFF_FFFE` to CYCLES, then read on the next cycles → `0xFFFF_FFFE`, `0xFFFF_FFFF`, `0x0000_0000`.
- Push 2 words, assert `reset` for 1 cycle mid-drain → `tx_valid` drops immediately and STATUS=`0x02` afterwards. A RAM word written before the reset still reads back unchanged.
